sim_run_controller: RTL and testbench

- Parametrised run controller for microprocessor simulation and bring-up.
- Replaces the fixed reset pulse and fixed run time with a configurable sequence:
  - holds the CPU in reset for a programmable number of cycles;
  - runs it under a cycle budget;
  - detects a halt (PC stuck) and counts retired instructions.
- Sits beside the microprocessor top: drives the CPU reset and observes the PC and write-back enable.
- Ends each run with a done flag and a status code.

---
 rtl/sim_run_controller.sv | 104 ++++++++++
 tb/tb_sim_run_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sim_run_controller.sv
// rtl/sim_run_controller.sv - CPU bring-up run controller: reset hold, cycle budget, halt detect
module sim_run_controller #(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 100,
    parameter int HALT_WINDOW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 wb_en,
    output logic                 cpu_rst,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    // Encodings double as the status code so status is a straight copy of the state register.
    typedef enum logic [1:0] {
        S_RUN        = 2'b00,
        S_HALTED     = 2'b01,
        S_TIMEOUT    = 2'b10,
        S_RESET_HOLD = 2'b11
    } state_t;

    localparam int HOLD_W   = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int STABLE_W = (HALT_WINDOW > 2) ? $clog2(HALT_WINDOW)    : 1;

    localparam logic [HOLD_W-1:0]    HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST = STABLE_W'(HALT_WINDOW - 2);
    localparam logic [CNT_WIDTH-1:0] CYCLE_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [STABLE_W-1:0]   stable_cnt;
    logic [PC_WIDTH-1:0]   last_pc;
    logic                  pc_valid;

    logic pc_same;
    logic halt_hit;
    logic timeout_hit;
    logic cycle_sat;
    logic instr_sat;

    // A halt needs a previous sample to compare against, so the first run sample never matches.
    assign pc_same     = pc_valid && (pc == last_pc);
    assign halt_hit    = pc_same && (stable_cnt == STABLE_LAST);
    assign timeout_hit = (cycle_count == CYCLE_LAST);
    assign cycle_sat   = &cycle_count;
    assign instr_sat   = &instr_count;
    assign status      = state;

    // Sequencer: reset hold, counted run, then a terminal state left only through rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET_HOLD;
            cpu_rst     <= 1'b1;
            done        <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            hold_cnt    <= '0;
            stable_cnt  <= '0;
            last_pc     <= '0;
            pc_valid    <= 1'b0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (run_en) begin
                        if (!cycle_sat) begin
                            cycle_count <= cycle_count + CNT_WIDTH'(1);
                        end
                        if (wb_en && !instr_sat) begin
                            instr_count <= instr_count + CNT_WIDTH'(1);
                        end
                        last_pc    <= pc;
                        pc_valid   <= 1'b1;
                        stable_cnt <= pc_same ? stable_cnt + STABLE_W'(1) : '0;
                        // Halt is checked first so a halt landing on the budget's last cycle wins.
                        if (halt_hit) begin
                            state <= S_HALTED;
                            done  <= 1'b1;
                        end else if (timeout_hit) begin
                            state <= S_TIMEOUT;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// tb/tb_sim_run_controller.sv - scoreboard bench for sim_run_controller
module tb_sim_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RST_CYCLES=3, MAX_CYCLES=10, HALT_WINDOW=4
    logic        a_rst = 1'b1, a_run_en = 1'b0, a_wb_en = 1'b0;
    logic [31:0] a_pc = '0;
    logic        a_cpu_rst, a_done;
    logic [1:0]  a_status;
    logic [31:0] a_cycle_count, a_instr_count;

    // Instance B: RST_CYCLES=2, MAX_CYCLES=6, HALT_WINDOW=2
    logic        b_rst = 1'b1, b_run_en = 1'b0, b_wb_en = 1'b0;
    logic [31:0] b_pc = '0;
    logic        b_cpu_rst, b_done;
    logic [1:0]  b_status;
    logic [31:0] b_cycle_count, b_instr_count;

    sim_run_controller #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(3), .MAX_CYCLES(10), .HALT_WINDOW(4)
    ) dut_a (
        .clk(clk), .rst(a_rst), .run_en(a_run_en), .pc(a_pc), .wb_en(a_wb_en),
        .cpu_rst(a_cpu_rst), .done(a_done), .status(a_status),
        .cycle_count(a_cycle_count), .instr_count(a_instr_count)
    );

    sim_run_controller #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(2), .MAX_CYCLES(6), .HALT_WINDOW(2)
    ) dut_b (
        .clk(clk), .rst(b_rst), .run_en(b_run_en), .pc(b_pc), .wb_en(b_wb_en),
        .cpu_rst(b_cpu_rst), .done(b_done), .status(b_status),
        .cycle_count(b_cycle_count), .instr_count(b_instr_count)
    );

    typedef struct {
        string       tag;
        logic [67:0] snap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [67:0] pack(input logic cr, input logic dn, input logic [1:0] st,
                                         input logic [31:0] cy, input logic [31:0] in);
        return {cr, dn, st, cy, in};
    endfunction

    // Drive one edge's inputs, queue the expected post-edge outputs, then pop and compare.
    task automatic step(input bit inst, input string tag,
                        input logic r, input logic re, input logic [31:0] p, input logic w,
                        input logic e_cr, input logic e_dn, input logic [1:0] e_st,
                        input int e_cy, input int e_in);
        exp_t        e;
        logic [67:0] obs;
        if (inst == 1'b0) begin
            a_rst = r; a_run_en = re; a_pc = p; a_wb_en = w;
        end else begin
            b_rst = r; b_run_en = re; b_pc = p; b_wb_en = w;
        end
        e.tag  = tag;
        e.snap = pack(e_cr, e_dn, e_st, e_cy, e_in);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (inst == 1'b0) obs = pack(a_cpu_rst, a_done, a_status, a_cycle_count, a_instr_count);
        else              obs = pack(b_cpu_rst, b_done, b_status, b_cycle_count, b_instr_count);
        e = sb.pop_front();
        checks++;
        assert (obs === e.snap) else begin
            errors++;
            $error("FAIL %s: observed cpu_rst=%b done=%b status=%b cyc=%0d ins=%0d expected cpu_rst=%b done=%b status=%b cyc=%0d ins=%0d",
                   e.tag, obs[67], obs[66], obs[65:64], obs[63:32], obs[31:0],
                   e.snap[67], e.snap[66], e.snap[65:64], e.snap[63:32], e.snap[31:0]);
        end
    endtask

    // rst asserted for one edge, then n hold edges with run_en/wb_en active to show they are ignored.
    task automatic reset_and_hold(input bit inst, input string tag, input int n);
        step(inst, {tag, "_rst"}, 1'b1, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 2'b11, 0, 0);
        for (int k = 1; k <= n; k++) begin
            step(inst, $sformatf("%s_hold%0d", tag, k), 1'b0, 1'b1, 32'h50 + 32'(k), 1'b1,
                 (k < n), 1'b0, (k < n) ? 2'b11 : 2'b00, 0, 0);
        end
    endtask

    initial begin
        logic [31:0] halt_pcs [7];
        halt_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC};

        // Reset timing: two rst edges, then cpu_rst high for 3 edges with run_en=0.
        step(0, "rst0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 0, 0);
        step(0, "rst1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, $sformatf("hold%0d", k), 1'b0, 1'b0, 32'h0, 1'b0,
                 (k < 3), 1'b0, (k < 3) ? 2'b11 : 2'b00, 0, 0);
        end

        // Halt: 0,4,8 then 0xC held; the 4th equal 0xC sample (7th run sample) halts.
        for (int i = 0; i < 7; i++) begin
            step(0, $sformatf("halt%0d", i), 1'b0, 1'b1, halt_pcs[i], (i < 3),
                 1'b0, (i == 6), (i == 6) ? 2'b01 : 2'b00, i + 1, (i < 3) ? i + 1 : 3);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, $sformatf("halt_frozen%0d", i), 1'b0, 1'b1, 32'h20 + 32'(4 * i), 1'b1,
                 1'b0, 1'b1, 2'b01, 7, 3);
        end

        // Reset from HALTED, then timeout with an advancing pc and wb_en always set.
        reset_and_hold(0, "to", 3);
        for (int i = 0; i < 10; i++) begin
            step(0, $sformatf("to%0d", i), 1'b0, 1'b1, 32'(4 * i), 1'b1,
                 1'b0, (i == 9), (i == 9) ? 2'b10 : 2'b00, i + 1, i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, $sformatf("to_frozen%0d", i), 1'b0, 1'b1, 32'(4 * (10 + i)), 1'b1,
                 1'b0, 1'b1, 2'b10, 10, 10);
        end

        // Reset from TIMEOUT, then pause with a stuck pc, then resume with pc advancing.
        reset_and_hold(0, "pz", 3);
        for (int i = 0; i < 3; i++) begin
            step(0, $sformatf("pz_pre%0d", i), 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b1,
                 1'b0, 1'b0, 2'b00, i + 1, i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, $sformatf("pz_hold%0d", i), 1'b0, 1'b0, 32'h108, 1'b1,
                 1'b0, 1'b0, 2'b00, 3, 3);
        end
        for (int i = 3; i < 6; i++) begin
            step(0, $sformatf("pz_post%0d", i), 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b0,
                 1'b0, 1'b0, 2'b00, i + 1, 3);
        end

        // Reset mid-run, then the sequence restarts from zero.
        reset_and_hold(0, "mid", 3);
        for (int i = 0; i < 2; i++) begin
            step(0, $sformatf("mid_run%0d", i), 1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b1,
                 1'b0, 1'b0, 2'b00, i + 1, i + 1);
        end

        // Simultaneous halt and timeout on instance B: samples 5 and 6 equal, budget 6.
        reset_and_hold(1, "sim", 2);
        for (int i = 0; i < 6; i++) begin
            step(1, $sformatf("sim%0d", i), 1'b0, 1'b1, (i == 5) ? 32'h20 : 32'h10 + 32'(4 * i), 1'b0,
                 1'b0, (i == 5), (i == 5) ? 2'b01 : 2'b00, i + 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
